ram_rd_streamer: RTL and testbench
==================================

Name: ram_rd_streamer

Overview:
- Read-side controller for port 1 (read-only) of the dual-port ram_proj macro.
- Accepts a burst command (start address and length) and issues port-1 reads.
- Compensates for the fixed macro read latency and buffers returned words in a small FIFO.
- Delivers the words as a valid/ready stream with a last flag, so the consumer can stall freely without losing data.

Parameters:
- DATA_W, 32: width of dout1 and of the output stream data.
- ADDR_W, 8: width of addr1; the macro holds 2^ADDR_W words.
- RD_LAT, 1: clock cycles from a cs1 assertion to valid dout1 data. Minimum 1.
- FIFO_DEPTH, 4: return buffer depth in words. Power of 2, minimum 2.

Ports:
- clk1  in  1  single clock, shared with the macro port 1
- rst1  in  1  synchronous, active-high reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  controller can accept a command
- cmd_addr  in  ADDR_W  first word address
- cmd_len  in  ADDR_W+1  number of words, 0 to 2^ADDR_W
- cs1  out  1  macro port-1 chip select; a read is issued on each cycle it is high
- addr1  out  ADDR_W  macro port-1 address
- dout1  in  DATA_W  macro port-1 read data
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accepts the word
- m_data  out  DATA_W  output word
- m_last  out  1  marks the final word of the burst
- done  out  1  one-cycle pulse when the burst is complete

Behaviour:
- Reset: takes effect on a clk1 edge while rst1=1. Clears the state to IDLE, the FIFO, the latency pipeline and all counters. Resulting outputs: cmd_ready=1, cs1=0, addr1=0, m_valid=0, m_data=0, m_last=0, done=0. Reset mid-burst discards in-flight and buffered data, and no done pulse is produced.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) latches cmd_addr into the read pointer and cmd_len into the remaining-issue count.
  - If cmd_len=0: no reads are issued, done pulses on the next cycle, and the state stays IDLE.
  - Otherwise: go to ISSUE.
  - cmd_ready=0 in all other states.
- ISSUE:
  - cs1=1 and addr1=pointer when credit exists: FIFO occupancy + reads in flight < FIFO_DEPTH.
  - Each issue increments the pointer modulo 2^ADDR_W (0xFF wraps to 0x00) and decrements the remaining count.
  - After the last issue, go to DRAIN.
  - When cs1=0, addr1 holds its last value.
- Latency pipeline: an RD_LAT-deep valid/last shift register tracks each issued read. When a tracked entry emerges, dout1 is written into the FIFO together with its last flag. The last flag is set on the read that took the remaining count to 0.
- Credit rule: the FIFO can never overflow, so cs1 deasserts whenever the FIFO is full or would fill from outstanding reads.
- Output stream:
  - m_valid is high whenever the FIFO is non-empty; m_data and m_last come from the FIFO head.
  - A transfer happens when m_valid & m_ready.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - First-word latency with m_ready held at 1: cmd handshake at cycle 0, cs1 at cycle 1, FIFO write at cycle 1+RD_LAT, m_valid at cycle 2+RD_LAT.
- DRAIN: exit when the word with m_last transfers. On that cycle go to IDLE; done pulses on the following cycle.
- Simultaneous FIFO push and pop when full is impossible under the credit rule. Push and pop on the same cycle in any other state leaves occupancy unchanged.
- cmd_len=2^ADDR_W reads the whole memory exactly once, starting at cmd_addr and wrapping.

Optional Feature:
- Macro: RD_STREAM_STATS_EN.
- When defined:
  - Adds output stat_words (32 bits): total words transferred on the stream since reset.
  - Adds output stat_stalls (32 bits): cycles with m_valid=1 and m_ready=0.
  - Both counters saturate at 0xFFFFFFFF and clear on rst1.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Package ram_rd_pkg holds:
  - state enum rd_state_e (IDLE, ISSUE, DRAIN)
  - default width constants RD_DATA_W=32 and RD_ADDR_W=8
- One sub-module is natural: rd_sync_fifo. It is a parameterised synchronous FIFO (width DATA_W+1 to carry data and last, depth FIFO_DEPTH) with push, pop, full, empty and count outputs.

Test Plan:
- Basic burst: preload addr 0x10..0x13 with 0xA0..0xA3; cmd addr=0x10 len=4, m_ready=1 → m_data A0, A1, A2, A3 in consecutive cycles; m_last only on A3; one done pulse.
- Wrap: cmd addr=0xFE len=4 → reads of addr1 0xFE, 0xFF, 0x00, 0x01, with data returned in that order.
- Backpressure: len=16 with m_ready=0 for 20 cycles → at most FIFO_DEPTH reads issued, no data lost, m_data stable. Then release m_ready → all 16 words in order.
- Zero length: cmd len=0 → no cs1 assertion; done pulses one cycle after the handshake; cmd_ready stays 1.
- Reset mid-burst: assert rst1 after 3 of 8 words → m_valid=0 and cmd_ready=1 the cycle after reset. A new cmd addr=0x20 len=2 then returns only mem[0x20] and mem[0x21].
- Full memory: len=256 from addr 0x80 with random m_ready → 256 words in address order 0x80..0xFF, 0x00..0x7F. With RD_STREAM_STATS_EN defined, stat_words=256.

Source files
------------

// File: rtl/ram_rd_streamer_pkg.sv
// ram_rd_pkg: shared types and default widths for the ram_rd_streamer slice.
//   rd_state_e : controller state encoding (IDLE, ISSUE, DRAIN)
//   RD_DATA_W  : default data width of the macro read port
//   RD_ADDR_W  : default address width of the macro read port
package ram_rd_pkg;

    localparam int RD_DATA_W = 32;
    localparam int RD_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/ram_rd_streamer_if.sv
// ram_rd_streamer_if: valid/ready word stream carrying data and a last flag.
//   m_valid : word available (producer)
//   m_ready : consumer accepts the word
//   m_data  : word payload, DATA_W bits
//   m_last  : final word of a burst
// Modports: master = producer side, slave = consumer side.
interface ram_rd_streamer_if #(
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/ram_rd_streamer_fifo.sv
// rd_sync_fifo: synchronous FIFO, WIDTH bits wide and DEPTH (power of 2) deep.
//   clk, srst   : clock and synchronous active-high reset
//   push        : write push_data (ignored when full)
//   pop         : advance the head (ignored when empty)
//   head_data   : current head word, visible combinationally
//   full, empty : occupancy flags
//   count       : number of stored words, 0..DEPTH
module rd_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head is read asynchronously so the stream sees a word the cycle after it lands.
    assign head_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/ram_rd_streamer.sv
// ram_rd_streamer: burst read controller for port 1 of the ram_proj macro.
// Accepts {cmd_addr, cmd_len}, issues cs1/addr1 reads only while the return
// FIFO has room for every outstanding word, and streams results with m_last.
//   clk1, rst1        : clock and synchronous active-high reset
//   cmd_valid/ready   : command handshake; cmd_addr start, cmd_len 0..2^ADDR_W
//   cs1, addr1, dout1 : macro port-1 read interface (dout1 valid RD_LAT after cs1)
//   m_stream          : output word stream (master modport)
//   done              : one-cycle pulse after the burst completes
// Optional build macro RD_STREAM_STATS_EN adds stat_words / stat_stalls
// (saturating 32-bit counters of stream transfers and stalled cycles).
module ram_rd_streamer
    import ram_rd_pkg::*;
#(
    parameter int DATA_W     = RD_DATA_W,
    parameter int ADDR_W     = RD_ADDR_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk1,
    input  logic                rst1,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W:0]     cmd_len,
    output logic                cs1,
    output logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   dout1,
    ram_rd_streamer_if.master   m_stream,
    output logic                done
`ifdef RD_STREAM_STATS_EN
    ,
    output logic [31:0]         stat_words,
    output logic [31:0]         stat_stalls
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FLT_W = $clog2(RD_LAT + 1);

    rd_state_e         state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] addr1_reg;
    logic [ADDR_W:0]   remain_reg;
    logic              done_reg;
    logic [RD_LAT-1:0] pipe_valid_reg, pipe_valid_next;
    logic [RD_LAT-1:0] pipe_last_reg, pipe_last_next;
    logic [FLT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic              cmd_fire, credit, issue, last_issue, push, pop, head_last;

    assign cmd_ready  = (state_reg == IDLE);
    assign cmd_fire   = cmd_valid && cmd_ready;

    // Reads still in the latency pipeline are counted against FIFO space,
    // including the one landing this cycle, so a push can never hit a full FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + FLT_W'(pipe_valid_reg[i]);
        end
    end

    assign credit     = !fifo_full && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
    assign issue      = (state_reg == ISSUE) && credit;
    assign last_issue = issue && (remain_reg == (ADDR_W+1)'(1));
    assign cs1        = issue;
    assign addr1      = issue ? ptr_reg : addr1_reg;

    // Latency tracker: stage 0 captures the issue, the tail stage marks dout1 valid.
    assign pipe_valid_next[0] = issue;
    assign pipe_last_next[0]  = last_issue;
    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_lat
            assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
            assign pipe_last_next[gi]  = pipe_last_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk1) begin
        if (rst1) begin
            pipe_valid_reg <= '0;
            pipe_last_reg  <= '0;
        end else begin
            pipe_valid_reg <= pipe_valid_next;
            pipe_last_reg  <= pipe_last_next;
        end
    end

    assign push = pipe_valid_reg[RD_LAT-1];

    rd_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk1),
        .srst      (rst1),
        .push      (push),
        .push_data ({pipe_last_reg[RD_LAT-1], dout1}),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Gate the head so the stream reads as zero whenever nothing is buffered.
    assign head_last        = !fifo_empty && fifo_head[DATA_W];
    assign m_stream.m_valid = !fifo_empty;
    assign m_stream.m_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign m_stream.m_last  = head_last;
    assign pop              = !fifo_empty && m_stream.m_ready;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (cmd_fire && (cmd_len != '0)) state_next = ISSUE;
            ISSUE:   if (last_issue) state_next = DRAIN;
            DRAIN:   if (pop && head_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst1) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            addr1_reg  <= '0;
            remain_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (cmd_fire && (cmd_len == '0)) ||
                         ((state_reg == DRAIN) && pop && head_last);
            if (cmd_fire) begin
                ptr_reg    <= cmd_addr;
                remain_reg <= cmd_len;
            end else if (issue) begin
                ptr_reg    <= ptr_reg + 1'b1;
                remain_reg <= remain_reg - 1'b1;
                addr1_reg  <= ptr_reg;
            end
        end
    end

    assign done = done_reg;

`ifdef RD_STREAM_STATS_EN
    logic [31:0] stat_words_reg;
    logic [31:0] stat_stalls_reg;

    always_ff @(posedge clk1) begin
        if (rst1) begin
            stat_words_reg  <= '0;
            stat_stalls_reg <= '0;
        end else begin
            if (pop && (stat_words_reg != '1)) begin
                stat_words_reg <= stat_words_reg + 1'b1;
            end
            if (!fifo_empty && !m_stream.m_ready && (stat_stalls_reg != '1)) begin
                stat_stalls_reg <= stat_stalls_reg + 1'b1;
            end
        end
    end

    assign stat_words  = stat_words_reg;
    assign stat_stalls = stat_stalls_reg;
`endif
endmodule

// File: tb/tb_ram_rd_streamer.sv
// Self-checking bench for ram_rd_streamer: a behavioural port-1 macro model,
// a negedge stream monitor, a table of bursts plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_ram_rd_streamer;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 4;

    logic              clk1 = 1'b0;
    logic              rst1 = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [ADDR_W:0]   cmd_len = '0;
    logic              cs1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] dout1;
    logic              done;
`ifdef RD_STREAM_STATS_EN
    logic [31:0]       stat_words;
    logic [31:0]       stat_stalls;
`endif

    ram_rd_streamer_if #(.DATA_W(DATA_W)) m_if ();

    always #5 clk1 = ~clk1;

    ram_rd_streamer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk1(clk1), .rst1(rst1),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cs1(cs1), .addr1(addr1), .dout1(dout1),
        .m_stream(m_if),
        .done(done)
`ifdef RD_STREAM_STATS_EN
        , .stat_words(stat_words), .stat_stalls(stat_stalls)
`endif
    );

    // Macro model: mem[a] = 0x90 + a, so 0x10..0x13 hold 0xA0..0xA3.
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] lat_q [RD_LAT];

    always @(posedge clk1) begin
        lat_q[0] <= cs1 ? mem[addr1] : 32'hDEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) lat_q[i] <= lat_q[i-1];
    end
    assign dout1 = lat_q[RD_LAT-1];

    // Monitor
    int                cyc = 0;
    logic [DATA_W-1:0] got_data [$];
    bit                got_last [$];
    int                got_cyc [$];
    logic [ADDR_W-1:0] iss_addr [$];
    int                done_cnt = 0, done_cyc = 0, hs_cyc = 0, unstable = 0;
    int                xfers = 0, stalls = 0;
    bit                prev_stall = 0;
    logic [DATA_W-1:0] prev_data = '0;
    logic              prev_last = 1'b0;

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (rst1) begin
            xfers = 0;
            stalls = 0;
            prev_stall = 0;
        end else begin
            if (cmd_valid && cmd_ready) hs_cyc = cyc;
            if (cs1) iss_addr.push_back(addr1);
            if (m_if.m_valid && m_if.m_ready) begin
                got_data.push_back(m_if.m_data);
                got_last.push_back(m_if.m_last);
                got_cyc.push_back(cyc);
                xfers++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_if.m_valid && !m_if.m_ready) begin
                stalls++;
                if (prev_stall && (m_if.m_data !== prev_data || m_if.m_last !== prev_last))
                    unstable++;
                prev_stall = 1;
                prev_data = m_if.m_data;
                prev_last = m_if.m_last;
            end else begin
                prev_stall = 0;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        iss_addr.delete();
        done_cnt = 0;
        unstable = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        for (int n = 0; n < 50 && !cmd_ready; n++) tick();
        check("cmd_ready_at_cmd", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            if (rnd) m_if.m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        m_if.m_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic verify_burst(input logic [ADDR_W-1:0] a, input int len);
        int oerr = 0;
        int lerr = 0;
        int ierr = 0;
        logic [ADDR_W-1:0] ea;
        check("word_count", got_data.size(), len);
        check("issue_count", iss_addr.size(), len);
        for (int i = 0; i < got_data.size(); i++) begin
            ea = a + 8'(i);
            if (got_data[i] !== mem[ea]) oerr++;
            if (got_last[i] != (i == len - 1)) lerr++;
        end
        for (int i = 0; i < iss_addr.size(); i++) begin
            ea = a + 8'(i);
            if (iss_addr[i] !== ea) ierr++;
        end
        check("data_order_errors", oerr, 0);
        check("last_flag_errors", lerr, 0);
        check("issue_addr_errors", ierr, 0);
        check("done_pulses", done_cnt, 1);
        if (got_cyc.size() > 0)
            check("done_timing", done_cyc, got_cyc[got_cyc.size()-1] + 1);
        check("stall_stability_errors", unstable, 0);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W:0]   len;
        bit                rnd;
        logic [DATA_W-1:0] exp_first;
        logic [DATA_W-1:0] exp_last;
    } vec_t;

    vec_t vecs [4];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h90 + 32'(i);
        m_if.m_ready = 1'b1;

        vecs[0] = '{8'h10, 9'd4,  1'b0, 32'hA0,  32'hA3};   // basic burst
        vecs[1] = '{8'hFE, 9'd4,  1'b0, 32'h18E, 32'h91};   // FE,FF,00,01
        vecs[2] = '{8'h40, 9'd1,  1'b0, 32'hD0,  32'hD0};   // single word
        vecs[3] = '{8'hF0, 9'd16, 1'b1, 32'h180, 32'h18F};  // random ready

        // Reset state
        tick(); tick(); tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cs1", cs1, 0);
        check("rst_addr1", addr1, 0);
        check("rst_m_valid", m_if.m_valid, 0);
        check("rst_m_data", m_if.m_data, 0);
        check("rst_m_last", m_if.m_last, 0);
        check("rst_done", done, 0);
        rst1 = 1'b0;
        tick();

        // Table-driven bursts
        for (int v = 0; v < 4; v++) begin
            clear_mon();
            send_cmd(vecs[v].addr, vecs[v].len);
            wait_done(2000, vecs[v].rnd);
            $display("burst addr=0x%02h len=%0d words=%0d done=%0d",
                     vecs[v].addr, vecs[v].len, got_data.size(), done_cnt);
            verify_burst(vecs[v].addr, int'(vecs[v].len));
            check("first_word", got_data.size() > 0 ? got_data[0] : 32'hFFFF_FFFF,
                  vecs[v].exp_first);
            check("last_word", got_data.size() > 0 ? got_data[got_data.size()-1] : 32'hFFFF_FFFF,
                  vecs[v].exp_last);
            if (!vecs[v].rnd && got_cyc.size() > 1) begin
                check("first_word_latency", got_cyc[0] - hs_cyc, 2 + RD_LAT);
                check("back_to_back", got_cyc[got_cyc.size()-1] - got_cyc[0], got_cyc.size() - 1);
            end
        end

        // Zero length
        clear_mon();
        send_cmd(8'h55, 9'd0);
        check("zero_done_next_cycle", done, 1);
        check("zero_cmd_ready", cmd_ready, 1);
        tick();
        check("zero_done_one_cycle", done, 0);
        tick(); tick(); tick();
        check("zero_no_reads", iss_addr.size(), 0);
        check("zero_done_pulses", done_cnt, 1);
        $display("zero-length cmd reads=%0d done=%0d", iss_addr.size(), done_cnt);

        // Backpressure
        clear_mon();
        m_if.m_ready = 1'b0;
        send_cmd(8'h60, 9'd16);
        repeat (20) tick();
        check("bp_reads_issued", iss_addr.size(), FIFO_DEPTH);
        check("bp_m_valid", m_if.m_valid, 1);
        check("bp_head_data", m_if.m_data, 32'hF0);
        check("bp_no_transfers", got_data.size(), 0);
        m_if.m_ready = 1'b1;
        wait_done(500, 1'b0);
        $display("backpressure burst words=%0d done=%0d", got_data.size(), done_cnt);
        verify_burst(8'h60, 16);

        // Reset mid-burst
        clear_mon();
        send_cmd(8'h30, 9'd8);
        for (int n = 0; n < 50 && got_data.size() < 3; n++) tick();
        check("pre_reset_words", got_data.size(), 3);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        check("post_rst_m_valid", m_if.m_valid, 0);
        check("post_rst_cmd_ready", cmd_ready, 1);
        tick(); tick(); tick();
        check("post_rst_no_done", done_cnt, 0);
        clear_mon();
        send_cmd(8'h20, 9'd2);
        wait_done(200, 1'b0);
        $display("post-reset burst words=%0d done=%0d", got_data.size(), done_cnt);
        check("post_rst_words", got_data.size(), 2);
        check("post_rst_word0", got_data.size() > 0 ? got_data[0] : 32'hFFFF_FFFF, 32'hB0);
        check("post_rst_word1", got_data.size() > 1 ? got_data[1] : 32'hFFFF_FFFF, 32'hB1);
        check("post_rst_done", done_cnt, 1);

        // Full memory with random ready, from a fresh reset
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        tick();
        clear_mon();
        send_cmd(8'h80, 9'd256);
        wait_done(5000, 1'b1);
        $display("full-memory burst words=%0d done=%0d stalls=%0d", got_data.size(), done_cnt, stalls);
        verify_burst(8'h80, 256);
`ifdef RD_STREAM_STATS_EN
        check("stat_words", stat_words, 256);
        check("stat_stalls", stat_stalls, stalls);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
